// File: rtl/byte_store_ctrl.sv
// -----------------------------------------------------------------------------
// byte_store_ctrl
//   Front-end controller for the 8-bit byte memory latch. It synchronises and
//   debounces a raw push-button, captures the switch byte once per press and
//   emits a fixed-width store strobe while the captured byte is held stable.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable clocks needed to accept press/release
//   STORE_CYCLES     width of the store strobe in clocks
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   data_in      in   8-bit switch byte, captured on entry to LOAD
//   btn_store    in   raw asynchronous push-button, active high
//   data_out     out  captured byte, drives the memory data input
//   store        out  write strobe, drives the memory store input
//   busy         out  high in every state except IDLE
//   store_count  out  completed writes, wraps at 256
// -----------------------------------------------------------------------------
module byte_store_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STORE_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       btn_store,
  output logic [7:0] data_out,
  output logic       store,
  output logic       busy,
  output logic [7:0] store_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int STB_W = $clog2(STORE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STORE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    LOAD     = 3'd2,
    STROBE   = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t           state;
  logic             sync_p0;
  logic             btn_s;
  logic [CNT_W-1:0] db_cnt;
  logic [STB_W-1:0] stb_cnt;

  // Stage p0 -> btn_s: two-flop synchroniser on the raw button
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_p0 <= btn_store;
      btn_s   <= sync_p0;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      db_cnt      <= '0;
      stb_cnt     <= '0;
      data_out    <= 8'h00;
      store       <= 1'b0;
      busy        <= 1'b0;
      store_count <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state  <= PRESS_DB;
            db_cnt <= '0;
            busy   <= 1'b1;
          end
        end

        PRESS_DB: begin
          if (!btn_s) begin
            // Press did not stay high long enough: treat as a glitch.
            state  <= IDLE;
            db_cnt <= '0;
            busy   <= 1'b0;
          end else if (db_cnt == DB_LAST) begin
            // The byte is captured on the edge that enters LOAD so data_out is
            // already stable for a full cycle before the strobe rises.
            state    <= LOAD;
            db_cnt   <= '0;
            data_out <= data_in;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end

        LOAD: begin
          state   <= STROBE;
          store   <= 1'b1;
          stb_cnt <= '0;
        end

        STROBE: begin
          if (stb_cnt == STB_LAST) begin
            state       <= RELEASE;
            store       <= 1'b0;
            db_cnt      <= '0;
            store_count <= store_count + 8'd1;
          end else begin
            stb_cnt <= stb_cnt + STB_W'(1);
          end
        end

        RELEASE: begin
          // Any bounce back high restarts the release qualification.
          if (btn_s) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state  <= IDLE;
            db_cnt <= '0;
            busy   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          db_cnt <= '0;
          store  <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_store_ctrl.sv
// -----------------------------------------------------------------------------
// tb_byte_store_ctrl
//   Bench for byte_store_ctrl. Instance dut_a uses D=4, S=1; instance dut_b uses
//   D=4, S=3 for the long-strobe and mid-strobe reset scenarios. Each press on
//   dut_a pushes its expected byte and count onto a queue; strobes observed on
//   dut_a pop that queue.
// -----------------------------------------------------------------------------
module tb_byte_store_ctrl;

  logic       clk;
  logic       reset_n_a, reset_n_b;
  logic [7:0] data_in;
  logic       btn_a, btn_b;
  logic [7:0] data_out_a, data_out_b;
  logic       store_a, store_b;
  logic       busy_a, busy_b;
  logic [7:0] store_count_a, store_count_b;

  byte_store_ctrl #(.DEBOUNCE_CYCLES(4), .STORE_CYCLES(1)) dut_a (
    .clk(clk), .reset_n(reset_n_a), .data_in(data_in), .btn_store(btn_a),
    .data_out(data_out_a), .store(store_a), .busy(busy_a),
    .store_count(store_count_a)
  );

  byte_store_ctrl #(.DEBOUNCE_CYCLES(4), .STORE_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .data_in(data_in), .btn_store(btn_b),
    .data_out(data_out_b), .store(store_b), .busy(busy_b),
    .store_count(store_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic       have_cur;
  logic       prev_store;
  int         stb_len;
  logic [7:0] exp_cnt;
  int         checks;
  int         errors;

  // Advance one clock and sample 1 time unit after the edge; the scoreboard on
  // dut_a is evaluated at every sample point.
  task automatic tick();
    @(posedge clk);
    #1;
    if (store_a && !prev_store) begin
      stb_len = 1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        have_cur = 1'b0;
        $display("FAIL unexpected_strobe data_out=%h expected no strobe", data_out_a);
      end else begin
        cur = exp_q.pop_front();
        have_cur = 1'b1;
        if (data_out_a !== cur.data) begin
          errors++;
          $display("FAIL strobe_data got=%h expected=%h", data_out_a, cur.data);
        end
      end
    end else if (store_a) begin
      stb_len++;
    end else if (prev_store) begin
      checks++;
      if (stb_len != 1) begin
        errors++;
        $display("FAIL strobe_width got=%0d expected=1", stb_len);
      end
      if (have_cur) begin
        checks++;
        if (store_count_a !== cur.cnt) begin
          errors++;
          $display("FAIL strobe_count got=%0d expected=%0d", store_count_a, cur.cnt);
        end
      end
    end
    prev_store = store_a;
  endtask

  task automatic press(input logic [7:0] d, input int hold, input int low);
    data_in = d;
    btn_a   = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back('{d, exp_cnt});
    repeat (hold) tick();
    btn_a = 1'b0;
    repeat (low) tick();
  endtask

  task automatic test_reset();
    reset_n_a = 1'b0;
    reset_n_b = 1'b0;
    btn_a     = 1'b1;
    btn_b     = 1'b1;
    data_in   = 8'hFF;
    repeat (3) tick();
    checks++;
    if ({data_out_a, store_a, busy_a, store_count_a} !== 18'd0) begin
      errors++;
      $display("FAIL reset_a got=%h/%b/%b/%h expected all zero",
               data_out_a, store_a, busy_a, store_count_a);
    end
    checks++;
    if ({data_out_b, store_b, busy_b, store_count_b} !== 18'd0) begin
      errors++;
      $display("FAIL reset_b got=%h/%b/%b/%h expected all zero",
               data_out_b, store_b, busy_b, store_count_b);
    end
    btn_a = 1'b0;
    btn_b = 1'b0;
    exp_q.delete();
    exp_cnt  = 8'd0;
    have_cur = 1'b0;
    reset_n_a = 1'b1;
    reset_n_b = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy_a=%b busy_b=%b expected 0", busy_a, busy_b);
    end
  endtask

  task automatic test_clean_press();
    data_in = 8'hA5;
    btn_a   = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back('{8'hA5, exp_cnt});
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (store_a !== (k == 7)) begin
        errors++;
        $display("FAIL press_store edge=%0d got=%b expected=%b", k, store_a, (k == 7));
      end
      checks++;
      if (data_out_a !== ((k >= 6) ? 8'hA5 : 8'h00)) begin
        errors++;
        $display("FAIL press_data edge=%0d got=%h expected=%h", k, data_out_a,
                 (k >= 6) ? 8'hA5 : 8'h00);
      end
      checks++;
      if (busy_a !== (k >= 2)) begin
        errors++;
        $display("FAIL press_busy edge=%0d got=%b expected=%b", k, busy_a, (k >= 2));
      end
      checks++;
      if (store_count_a !== ((k >= 8) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL press_count edge=%0d got=%0d expected=%0d", k, store_count_a,
                 (k >= 8) ? 1 : 0);
      end
    end
    btn_a = 1'b0;
    repeat (8) tick();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL press_release busy=%b expected 0", busy_a);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] saved_data;
    logic [7:0] saved_cnt;
    saved_data = data_out_a;
    saved_cnt  = store_count_a;
    data_in = 8'h5A;
    btn_a   = 1'b1;
    tick();
    tick();
    btn_a = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (store_a !== 1'b0) begin
        errors++;
        $display("FAIL glitch_store cycle=%0d got=%b expected 0", k, store_a);
      end
    end
    checks++;
    if (data_out_a !== saved_data || store_count_a !== saved_cnt || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL glitch_state data=%h cnt=%0d busy=%b expected data=%h cnt=%0d busy=0",
               data_out_a, store_count_a, busy_a, saved_data, saved_cnt);
    end
  endtask

  task automatic test_held_button();
    data_in = 8'h3C;
    btn_a   = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back('{8'h3C, exp_cnt});
    repeat (12) tick();
    data_in = 8'hC3;
    repeat (38) tick();
    checks++;
    if (data_out_a !== 8'h3C || store_count_a !== exp_cnt || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL held_state data=%h cnt=%0d busy=%b expected data=3c cnt=%0d busy=1",
               data_out_a, store_count_a, busy_a, exp_cnt);
    end
    btn_a = 1'b0;
    repeat (8) tick();
    checks++;
    if (busy_a !== 1'b0 || data_out_a !== 8'h3C) begin
      errors++;
      $display("FAIL held_release busy=%b data=%h expected busy=0 data=3c", busy_a, data_out_a);
    end
    press(8'hC3, 12, 8);
    checks++;
    if (data_out_a !== 8'hC3 || store_count_a !== exp_cnt) begin
      errors++;
      $display("FAIL held_second data=%h cnt=%0d expected data=c3 cnt=%0d",
               data_out_a, store_count_a, exp_cnt);
    end
  endtask

  task automatic test_release_bounce();
    data_in = 8'h96;
    btn_a   = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back('{8'h96, exp_cnt});
    repeat (12) tick();
    // Button pattern sampled at edges 0..: 0,0,1,0,0,... ; FSM sees it two
    // edges later, so the release qualifies on edge 8.
    btn_a = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      btn_a = (k == 1);
      checks++;
      if (busy_a !== (k < 8)) begin
        errors++;
        $display("FAIL bounce_busy edge=%0d got=%b expected=%b", k, busy_a, (k < 8));
      end
      checks++;
      if (store_a !== 1'b0) begin
        errors++;
        $display("FAIL bounce_store edge=%0d got=%b expected 0", k, store_a);
      end
    end
    btn_a = 1'b0;
  endtask

  task automatic test_wrap();
    reset_n_a = 1'b0;
    tick();
    exp_q.delete();
    exp_cnt   = 8'd0;
    have_cur  = 1'b0;
    reset_n_a = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      press(8'($urandom), 10, 8);
    end
    checks++;
    if (store_count_a !== 8'd0) begin
      errors++;
      $display("FAIL wrap_count got=%0d expected 0", store_count_a);
    end
  endtask

  task automatic test_midop_reset();
    data_in = 8'h77;
    btn_b   = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      checks++;
      if (store_b !== (k >= 7 && k <= 9)) begin
        errors++;
        $display("FAIL long_store edge=%0d got=%b expected=%b", k, store_b, (k >= 7 && k <= 9));
      end
    end
    checks++;
    if (store_count_b !== 8'd1 || data_out_b !== 8'h77) begin
      errors++;
      $display("FAIL long_result cnt=%0d data=%h expected cnt=1 data=77",
               store_count_b, data_out_b);
    end
    btn_b = 1'b0;
    repeat (8) tick();
    data_in = 8'h88;
    btn_b   = 1'b1;
    repeat (8) tick();
    checks++;
    if (store_b !== 1'b1 || data_out_b !== 8'h88) begin
      errors++;
      $display("FAIL midop_strobe store=%b data=%h expected store=1 data=88", store_b, data_out_b);
    end
    reset_n_b = 1'b0;
    btn_b     = 1'b0;
    tick();
    checks++;
    if ({data_out_b, store_b, busy_b, store_count_b} !== 18'd0) begin
      errors++;
      $display("FAIL midop_reset got=%h/%b/%b/%0d expected all zero",
               data_out_b, store_b, busy_b, store_count_b);
    end
    reset_n_b = 1'b1;
    repeat (4) tick();
    checks++;
    if (busy_b !== 1'b0 || store_count_b !== 8'd0) begin
      errors++;
      $display("FAIL midop_after busy=%b cnt=%0d expected busy=0 cnt=0", busy_b, store_count_b);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    prev_store = 1'b0;
    have_cur   = 1'b0;
    stb_len    = 0;
    exp_cnt    = 8'd0;
    reset_n_a  = 1'b0;
    reset_n_b  = 1'b0;
    btn_a      = 1'b0;
    btn_b      = 1'b0;
    data_in    = 8'h00;

    test_reset();
    test_clean_press();
    test_glitch();
    test_held_button();
    test_release_bounce();
    test_wrap();
    test_midop_reset();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes got=%0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
